// File: rtl/rr_grant_arbiter_if.sv
// Bundle between the three requesters / shared resource and the round-robin arbiter.
// master = requester/resource side, slave = arbiter side.
interface rr_grant_arbiter_if;
  logic [2:0] request;
  logic       done;
  logic [1:0] grant;
  logic [2:0] gnt_onehot;
  logic       busy;
  logic       timeout;

  modport master (
    output request,
    output done,
    input  grant,
    input  gnt_onehot,
    input  busy,
    input  timeout
  );

  modport slave (
    input  request,
    input  done,
    output grant,
    output gnt_onehot,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Three-requester round-robin arbiter with a per-owner hold limit (MAX_HOLD).
// An owner keeps the resource until done, request drop, or hold expiry; all outputs are registered.
module rr_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_grant_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_e;

  state_e     state_r;
  state_e     state_nxt_s;
  logic [1:0] ptr_r;
  logic [1:0] ptr_nxt_s;
  logic [1:0] owner_r;
  logic [1:0] owner_nxt_s;
  logic [7:0] hold_r;
  logic [7:0] hold_nxt_s;
  logic [1:0] grant_r;
  logic [1:0] grant_nxt_s;
  logic [2:0] onehot_r;
  logic [2:0] onehot_nxt_s;
  logic       busy_r;
  logic       busy_nxt_s;
  logic       timeout_r;
  logic       timeout_nxt_s;
  logic [2:0] pick_s;
  logic       owner_req_s;
  logic       at_limit_s;
  logic       exit_s;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    logic [1:0] r;
    case (x)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Returns {found, index}: first set request scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] rot;
    logic [1:0] base;
    logic [2:0] r;
    case (ptr)
      2'd1: begin
        rot  = {req[0], req[2], req[1]};
        base = 2'd1;
      end
      2'd2: begin
        rot  = {req[1], req[0], req[2]};
        base = 2'd2;
      end
      default: begin
        rot  = req;
        base = 2'd0;
      end
    endcase
    if (rot[0]) begin
      r = {1'b1, base};
    end else if (rot[1]) begin
      r = {1'b1, inc3(base)};
    end else if (rot[2]) begin
      r = {1'b1, inc3(inc3(base))};
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  assign pick_s     = rr_pick(bus.request, ptr_r);
  assign at_limit_s = (hold_r == MAX_HOLD_C);
  assign exit_s     = bus.done | ~owner_req_s | at_limit_s;

  // Request line of the current owner
  always_comb begin
    owner_req_s = 1'b0;
    case (owner_r)
      2'd0:    owner_req_s = bus.request[0];
      2'd1:    owner_req_s = bus.request[1];
      2'd2:    owner_req_s = bus.request[2];
      default: owner_req_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; any stray encoding falls back to IDLE
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (exit_s) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      RELEASE: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output / datapath next values, aligned with the next state so outputs can be registered
  always_comb begin
    owner_nxt_s   = owner_r;
    ptr_nxt_s     = ptr_r;
    hold_nxt_s    = 8'd0;
    timeout_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          owner_nxt_s = pick_s[1:0];
          hold_nxt_s  = 8'd1;
        end else begin
          owner_nxt_s = owner_r;
        end
      end
      GRANT: begin
        if (exit_s) begin
          ptr_nxt_s     = inc3(owner_r);
          // Only a pure hold expiry counts as a timeout; done and request drop win
          timeout_nxt_s = at_limit_s & ~bus.done & owner_req_s;
        end else begin
          hold_nxt_s = hold_r + 8'd1;
        end
      end
      RELEASE: owner_nxt_s = owner_r;
      default: owner_nxt_s = 2'd0;
    endcase

    if (state_nxt_s == GRANT) begin
      grant_nxt_s  = owner_nxt_s + 2'd1;
      onehot_nxt_s = 3'b001 << owner_nxt_s;
      busy_nxt_s   = 1'b1;
    end else begin
      grant_nxt_s  = 2'b00;
      onehot_nxt_s = 3'b000;
      busy_nxt_s   = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= 2'd0;
      owner_r   <= 2'd0;
      hold_r    <= 8'd0;
      grant_r   <= 2'b00;
      onehot_r  <= 3'b000;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      ptr_r     <= ptr_nxt_s;
      owner_r   <= owner_nxt_s;
      hold_r    <= hold_nxt_s;
      grant_r   <= grant_nxt_s;
      onehot_r  <= onehot_nxt_s;
      busy_r    <= busy_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign bus.grant      = grant_r;
  assign bus.gnt_onehot = onehot_r;
  assign bus.busy       = busy_r;
  assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: stimulus queues expected outputs, a monitor pops and compares.
// Expected vector packing: {grant[1:0], gnt_onehot[2:0], busy, timeout}.
module tb_rr_grant_arbiter;
  localparam logic [6:0] E_IDLE = 7'b00_000_0_0;
  localparam logic [6:0] E_G0   = 7'b01_001_1_0;
  localparam logic [6:0] E_G1   = 7'b10_010_1_0;
  localparam logic [6:0] E_G2   = 7'b11_100_1_0;
  localparam logic [6:0] E_TO   = 7'b00_000_0_1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  rr_grant_arbiter_if bus_if();

  rr_grant_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] expv);
    logic [6:0] got;
    got = {bus_if.grant, bus_if.gnt_onehot, bus_if.busy, bus_if.timeout};
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got grant=%b onehot=%b busy=%b timeout=%b, want grant=%b onehot=%b busy=%b timeout=%b",
               tag, got[6:5], got[4:2], got[1], got[0], expv[6:5], expv[4:2], expv[1], expv[0]);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge
  task automatic step(input string tag, input logic [2:0] req, input logic dn, input logic [6:0] expv);
    @(negedge clk);
    bus_if.request = req;
    bus_if.done    = dn;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare registered outputs just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  initial begin
    bus_if.request = 3'b000;
    bus_if.done    = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", E_IDLE);
    step("reset_hold", 3'b000, 1'b0, E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, done after a few cycles; release moves ptr to 1
    step("idle_pre",    3'b000, 1'b0, E_IDLE);
    step("g0_first",    3'b001, 1'b0, E_G0);
    step("g0_hold2",    3'b001, 1'b0, E_G0);
    step("g0_hold3",    3'b001, 1'b0, E_G0);
    step("g0_done_rel", 3'b001, 1'b1, E_IDLE);
    step("g0_idle",     3'b000, 1'b0, E_IDLE);

    // All requesting: rotation 1 -> 2 -> 0 -> 1 with two empty cycles between owners
    step("rr_g1",       3'b111, 1'b0, E_G1);
    step("rr_g1_rel",   3'b111, 1'b1, E_IDLE);
    step("rr_gap1",     3'b111, 1'b0, E_IDLE);
    step("rr_g2",       3'b111, 1'b0, E_G2);
    step("rr_g2_rel",   3'b111, 1'b1, E_IDLE);
    step("rr_gap2",     3'b111, 1'b0, E_IDLE);
    step("rr_g0_wrap",  3'b111, 1'b0, E_G0);
    step("rr_g0_rel",   3'b111, 1'b1, E_IDLE);
    step("rr_gap3",     3'b111, 1'b0, E_IDLE);
    step("rr_g1_again", 3'b111, 1'b0, E_G1);
    step("rr_g1b_rel",  3'b111, 1'b1, E_IDLE);
    step("rr_idle",     3'b000, 1'b0, E_IDLE);

    // Hold expiry: exactly 8 grant cycles, then a one-cycle timeout in release
    for (int i = 0; i < 8; i++) step("hold_g1", 3'b010, 1'b0, E_G1);
    step("hold_timeout", 3'b010, 1'b0, E_TO);
    step("hold_to_clear", 3'b000, 1'b0, E_IDLE);

    // Owner 0 not preempted by requester 1; dropping request releases without timeout
    step("own0",        3'b011, 1'b0, E_G0);
    step("own0_nopre",  3'b011, 1'b0, E_G0);
    step("own0_nopre2", 3'b011, 1'b0, E_G0);
    step("own0_drop",   3'b010, 1'b0, E_IDLE);
    step("drop_gap",    3'b010, 1'b0, E_IDLE);
    step("own1_after",  3'b010, 1'b0, E_G1);
    step("own1_rel",    3'b010, 1'b1, E_IDLE);
    step("own1_idle",   3'b000, 1'b0, E_IDLE);

    // done coincides with the hold limit: normal release, no timeout
    for (int i = 0; i < 8; i++) step("lim_g2", 3'b100, 1'b0, E_G2);
    step("lim_done_rel", 3'b100, 1'b1, E_IDLE);
    step("lim_idle",     3'b000, 1'b0, E_IDLE);

    // Released owner still requesting yields to the other requester
    step("fair_g0",   3'b101, 1'b0, E_G0);
    step("fair_rel",  3'b101, 1'b1, E_IDLE);
    step("fair_gap",  3'b101, 1'b0, E_IDLE);
    step("fair_g2",   3'b101, 1'b0, E_G2);
    step("fair_rel2", 3'b101, 1'b1, E_IDLE);
    step("fair_idle", 3'b000, 1'b0, E_IDLE);

    // Leave ptr at 2 with owner 1 granted, then reset asynchronously mid-grant
    step("pre_g1",  3'b010, 1'b0, E_G1);
    step("pre_rel", 3'b010, 1'b1, E_IDLE);
    step("pre_gap", 3'b010, 1'b0, E_IDLE);
    step("pre_g1b", 3'b010, 1'b0, E_G1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1 check("rst_mid_grant", E_IDLE);
    step("in_reset", 3'b000, 1'b0, E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // First arbitration after reset must scan from ptr 0
    step("post_idle",  3'b000, 1'b0, E_IDLE);
    step("post_ptr0",  3'b111, 1'b0, E_G0);
    step("post_rel",   3'b111, 1'b1, E_IDLE);
    step("post_gap",   3'b000, 1'b0, E_IDLE);
    step("post_g2",    3'b100, 1'b0, E_G2);
    step("post_rel2",  3'b100, 1'b1, E_IDLE);
    step("post_idle2", 3'b000, 1'b0, E_IDLE);

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
